// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store in flight, fixed wait states, then a one-cycle ready strobe.
// Optional address checking (misaligned / out of range) is enabled by defining DMEM_FAULT_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] memAddr,
  input  logic [31:0] memWData,
  output logic [31:0] memRData,
  output logic        memReady,
  output logic        memStall,
  output logic        memFault
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            rd_q, wr_q, bad_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            req, capture, fire;
  logic            live_bad;
  logic [AW-1:0]   cur_idx;
  logic            cur_rd, cur_wr, cur_bad;

  assign req     = memRead | memWrite;
  assign capture = (state == IDLE) && req;

`ifdef DMEM_FAULT_CHECK_EN
  assign live_bad = (memAddr[1:0] != 2'b00) || ((memAddr >> (AW + 2)) != 32'd0);
`else
  logic unused_addr_bits;
  assign live_bad         = 1'b0;
  assign unused_addr_bits = ^{memAddr[1:0], memAddr[31:AW+2]};
`endif

  // With LATENCY=1 the access completes on the capture edge itself, so it
  // must see the live request; otherwise it uses the latched copy.
  always_comb begin
    if (state == IDLE) begin
      cur_idx = memAddr[AW+1:2];
      cur_rd  = memRead;
      cur_wr  = memWrite;
      cur_bad = live_bad;
    end else begin
      cur_idx = idx_q;
      cur_rd  = rd_q;
      cur_wr  = wr_q;
      cur_bad = bad_q;
    end
  end

  assign fire = (capture && (LATENCY == 1)) || ((state == BUSY) && (cnt == 4'd1));

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      bad_q    <= 1'b0;
      memRData <= 32'd0;
      memReady <= 1'b0;
      memFault <= 1'b0;
    end else begin
      state    <= state_nxt;
      memReady <= fire;
      memFault <= fire && ((cur_rd && cur_wr) || cur_bad);
      if (capture) begin
        cnt     <= LOAD;
        idx_q   <= memAddr[AW+1:2];
        wdata_q <= memWData;
        rd_q    <= memRead;
        wr_q    <= memWrite;
        bad_q   <= live_bad;
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (fire) begin
        if (cur_bad)
          memRData <= 32'd0;
        else if (cur_rd && !cur_wr)
          memRData <= mem[cur_idx];
      end
    end
  end

  // NOTE: the array is deliberately not reset; only control state is.
  always_ff @(posedge clk) begin
    if (!rst && memReady && wr_q && !memFault)
      mem[idx_q] <= wdata_q;
  end

  assign memStall = req & ~memReady;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the load/store requests issued by the execute stage. It captures a single read or write request, holds it for a fixed number of wait states, then completes the access against an internal word array. It returns read data with a one-cycle `memReady` strobe and drives a combinational `memStall` so the pipeline freezes while the access is outstanding. Only one access is in flight at a time.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two, ≥ 4.
- `LATENCY`, default 2: cycles from request capture to `memReady`; legal range 1..15.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `memRead`  in  1  load request; held by the requester until `memReady`.
- `memWrite`  in  1  store request; held by the requester until `memReady`.
- `memAddr`  in  32  byte address (base + sign-extended imm).
- `memWData`  in  32  store data.
- `memRData`  out  32  load data; registered.
- `memReady`  out  1  one-cycle completion strobe.
- `memStall`  out  1  combinational: `(memRead|memWrite) & ~memReady`.
- `memFault`  out  1  one-cycle strobe, coincident with `memReady`, for an illegal access.

## Operation
- FSM states:
  - IDLE: capture a request when `memRead|memWrite`. Latch address, write data and kind. Load the counter with `LATENCY-1`. Go to BUSY.
  - BUSY: decrement the counter. At 0, perform the access, pulse `memReady`, go to DONE.
  - DONE: one turnaround cycle, no capture. Go to IDLE.
- Word index = `memAddr[log2(DEPTH_WORDS)+1:2]`.
- Read: the array is read at completion; `memRData` is updated on the `memReady` cycle and holds until the next completed read.
- Write: the array word is written on the clock edge that ends the `memReady` cycle. `memRData` is unchanged.
- `memRead` and `memWrite` both high at capture: treated as a fault (no access), regardless of the macro.
- Inputs are latched at capture. Changes during BUSY are ignored.
- Array contents are not reset and not initialised.
- Reset values: state IDLE, counter 0, `memRData` 0, `memReady` 0, `memFault` 0.
- Reset mid-operation: the pending access is discarded, and a pending write never commits.

## Timing
- Request seen high at edge N (captured) → `memReady` high during cycle N+LATENCY.
- DONE occupies cycle N+LATENCY+1. The earliest next capture is at edge N+LATENCY+2.
- Back-to-back throughput: one access per LATENCY+2 cycles.
- `memStall` is high from request assertion through cycle N+LATENCY-1, and low on the `memReady` cycle. In DONE it is high only if a new request is already asserted.
- Read-after-write to the same word: the write commits before the next capture, so the read returns the new data.

## Configuration
- `DMEM_FAULT_CHECK_EN` defined:
  - Applies to `memAddr[1:0] != 0` (misaligned) and to `memAddr >= 4*DEPTH_WORDS` (out of range).
  - Such an access completes with normal latency and `memReady=1`, `memFault=1`.
  - The array is not written, and `memRData` is forced to 32'h0.
- Undefined:
  - Low address bits are ignored, and upper bits beyond the index wrap modulo DEPTH_WORDS.
  - `memFault` asserts only for the simultaneous read+write case.

## Test plan
- Reset, then write 32'hCAFE_F00D to 0x10, then read 0x10 (LATENCY=2) → `memReady` at capture+2 both times; read returns 32'hCAFE_F00D; `memStall` high exactly 2 cycles per access.
- Back-to-back reads of 0x0 and 0x4 with requests held continuously → captures are 4 cycles apart; each `memReady` is a single-cycle pulse; DONE cycle shows no capture.
- Assert `rst` during BUSY of a write of 32'h1234 to 0x20, then read 0x20 → old contents returned; no `memReady` for the aborted write; outputs are 0 the cycle after reset.
- With the macro: read of 0x6 (misaligned) and write to 4*DEPTH_WORDS → `memFault=1`, `memRData=0`, array unchanged. Without the macro: write of 32'hAA to 4*DEPTH_WORDS → data lands in word 0.
- `memRead=memWrite=1` at 0x8 → `memFault=1` with `memReady`; word 0x8 unchanged.
- LATENCY=1 build: read completes with `memReady` the cycle after capture, and `memStall` is high for exactly 1 cycle.
